traffic_sink: RTL
=================

// Module: traffic_sink
// PURPOSE
//  Receive end of the trace-driven traffic flow. Sits at a ring node's ejection port.
//  Accepts delivered packets and timestamps each with a free-running cycle counter.
//  Logs {src,dest,arrival_cycle} in the same 40-bit entry format the trace generator
//  consumes, and accumulates latency statistics for trace-vs-arrival comparison.
// PARAMETERS
//  MY_ID       4'd0   node id of this sink; used for misroute detection
//  FIFO_DEPTH  4      ingress buffer entries (power of 2, >=2)
//  LOG_DEPTH   65536  log RAM entries (power of 2); LOG_AW = $clog2(LOG_DEPTH)
// PORTS
//  clk            in   1       single clock, all logic posedge
//  rst_n          in   1       asynchronous active-low reset
//  clr            in   1       sync clear of counters, stats, log pointer (not cyc_cnt)
//  pkt_valid      in   1       ejection port: packet present
//  pkt_ready      out  1       sink can accept; transfer when valid&&ready
//  pkt_src        in   4       source node id
//  pkt_dest       in   4       destination node id
//  pkt_inj_cycle  in   32      cycle stamp carried from injection
//  rd_en          in   1       log readback request (single-port RAM, wins over drain)
//  rd_addr        in   LOG_AW  readback address
//  rd_data        out  40      log entry, valid 1 cycle after rd_en
//  cyc_cnt        out  32      free-running cycle counter
//  rx_count       out  32      packets accepted
//  lat_sum        out  48      sum of latencies of accepted packets
//  lat_max        out  32      max latency seen
//  misroute_cnt   out  16      accepted packets with pkt_dest != MY_ID
//  drop_cnt       out  16      packets dropped because log full
//  log_count      out  LOG_AW+1 entries written to log
//  log_full       out  1       log_count == LOG_DEPTH
// BEHAVIOUR
//  - Reset: all outputs 0, incl. pkt_ready, rd_data and cyc_cnt; FIFO empty. pkt_ready may rise on the first clk edge after rst_n deasserts.
//  - cyc_cnt: +1 every cycle, wraps 2^32; not affected by clr.
//  - pkt_ready = !fifo_full && !clr (registered-equivalent, no combinational path from pkt_valid).
//  - Accept (valid&&ready) at cycle T: arrival=cyc_cnt(T); latency=(arrival-pkt_inj_cycle) mod 2^32.
//    Same edge: rx_count+1, lat_sum+=latency (48b, wraps), lat_max=max, misroute_cnt+1 if dest!=MY_ID
//    (misrouted packets still logged); push {src,dest,arrival} into FIFO.
//  - Entry format: [39:36] src, [35:32] dest, [31:0] arrival cycle.
//  - Drain: when FIFO non-empty and !rd_en: pop one entry per cycle. If !log_full, write RAM[log_count] and log_count+1. Else discard and drop_cnt+1.
//  - rd_en: RAM read, rd_data <= RAM[rd_addr] next edge; drain stalls that cycle; rd_data holds otherwise.
//  - Simultaneous push and pop on a full FIFO not possible (ready low); push+pop otherwise legal.
//  - Counters 16b saturate at 0xFFFF; rx_count wraps.
//  - clr: next edge zeroes rx_count, lat_*, misroute/drop counts, log_count, empties FIFO. RAM contents untouched; accept blocked that cycle.
//  - rst_n low mid-transfer: FIFO and stats lost; RAM contents undefined-but-unchanged; no partial entry written.
// STRUCTURE
//  - Shared package/header: ENTRY_W=40, SRC_MSB/LSB=39/36, DEST_MSB/LSB=35/32, CYC_MSB/LSB=31/0, NODE_W=4. Generator and sink use the same constants.
//  - Sub-module sink_fifo: sync FIFO, WIDTH=40, DEPTH=FIFO_DEPTH, async rst_n, push/pop/full/empty.
//  - Top holds cycle counter, stats datapath, drain control, single-port log RAM inferred.
// TESTING
//  1 Packet src=2 dest=MY_ID inj=90 accepted at cyc_cnt=100 -> latency 10, rx_count=1; lat_max=10; RAM[0]=0x2_0_00000064.
//  2 rd_en held 6 cycles, 6 back-to-back packets -> 4 accepted, pkt_ready=0; rd_en released -> 4 entries logged in order; remaining 2 accepted.
//  3 LOG_DEPTH=8, 10 packets -> log_count=8, log_full=1, drop_cnt=2, RAM[7] = 8th packet.
//  4 inj=0xFFFF_FFF0, arrival 0x0000_0010 -> latency 0x20, lat_max=0x20.
//  5 dest=MY_ID+1 -> misroute_cnt=1, entry still logged.
//  6 clr with pkt_valid high -> that cycle pkt_ready=0, stats 0, log_count 0. rst_n pulse mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/traffic_sink_pkg.sv
// Shared log-entry layout for the trace generator and the traffic sink.
package traffic_sink_pkg;

    localparam int ENTRY_W  = 40;
    localparam int NODE_W   = 4;
    localparam int CYC_W    = 32;
    localparam int SRC_MSB  = 39;
    localparam int SRC_LSB  = 36;
    localparam int DEST_MSB = 35;
    localparam int DEST_LSB = 32;
    localparam int CYC_MSB  = 31;
    localparam int CYC_LSB  = 0;

    typedef struct packed {
        logic [NODE_W-1:0] src;
        logic [NODE_W-1:0] dest;
        logic [CYC_W-1:0]  cyc;
    } log_entry_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [NODE_W-1:0] src,
                                                      input logic [NODE_W-1:0] dest,
                                                      input logic [CYC_W-1:0]  cyc);
        logic [ENTRY_W-1:0] e;
        e                    = '0;
        e[SRC_MSB:SRC_LSB]   = src;
        e[DEST_MSB:DEST_LSB] = dest;
        e[CYC_MSB:CYC_LSB]   = cyc;
        return e;
    endfunction

endpackage

// File: rtl/traffic_sink_fifo.sv
// Synchronous ingress FIFO with synchronous clear; extra pointer bit separates full from empty.
module sink_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_sink.sv
// Ejection-port sink: timestamps accepted packets, buffers them, drains them into a
// single-port log RAM and keeps latency / misroute / drop statistics.
module traffic_sink
    import traffic_sink_pkg::*;
#(
    parameter logic [NODE_W-1:0] MY_ID      = 4'd0,
    parameter int                FIFO_DEPTH = 4,
    parameter int                LOG_DEPTH  = 65536,
    localparam int               LOG_AW     = $clog2(LOG_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               pkt_valid,
    output logic               pkt_ready,
    input  logic [NODE_W-1:0]  pkt_src,
    input  logic [NODE_W-1:0]  pkt_dest,
    input  logic [CYC_W-1:0]   pkt_inj_cycle,
    input  logic               rd_en,
    input  logic [LOG_AW-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [CYC_W-1:0]   cyc_cnt,
    output logic [31:0]        rx_count,
    output logic [47:0]        lat_sum,
    output logic [31:0]        lat_max,
    output logic [15:0]        misroute_cnt,
    output logic [15:0]        drop_cnt,
    output logic [LOG_AW:0]    log_count,
    output logic               log_full
);

    localparam logic [LOG_AW:0] LOG_LIMIT = (LOG_AW + 1)'(LOG_DEPTH);

    logic               rdy_en;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               drain;
    logic               log_wr;
    logic [ENTRY_W-1:0] fifo_dout;
    logic [CYC_W-1:0]   latency;
    logic [ENTRY_W-1:0] log_mem [LOG_DEPTH];

    // rdy_en keeps pkt_ready low through reset even though the FIFO reads as not full.
    assign pkt_ready = rdy_en && !fifo_full && !clr;
    assign accept    = pkt_valid && pkt_ready;
    assign latency   = cyc_cnt - pkt_inj_cycle;
    assign drain     = !fifo_empty && !rd_en && !clr;
    assign log_full  = (log_count == LOG_LIMIT);
    assign log_wr    = drain && !log_full;

    sink_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (accept),
        .push_data (pack_entry(pkt_src, pkt_dest, cyc_cnt)),
        .pop       (drain),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            rdy_en  <= 1'b0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            rdy_en  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_count     <= '0;
            lat_sum      <= '0;
            lat_max      <= '0;
            misroute_cnt <= '0;
            drop_cnt     <= '0;
            log_count    <= '0;
        end else if (clr) begin
            rx_count     <= '0;
            lat_sum      <= '0;
            lat_max      <= '0;
            misroute_cnt <= '0;
            drop_cnt     <= '0;
            log_count    <= '0;
        end else begin
            if (accept) begin
                rx_count <= rx_count + 1'b1;
                lat_sum  <= lat_sum + {16'h0000, latency};
                if (latency > lat_max) begin
                    lat_max <= latency;
                end
                if (pkt_dest != MY_ID && misroute_cnt != 16'hFFFF) begin
                    misroute_cnt <= misroute_cnt + 1'b1;
                end
            end
            if (drain) begin
                if (!log_full) begin
                    log_count <= log_count + 1'b1;
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    // Log RAM has no reset so it maps onto a plain single-port block RAM.
    always_ff @(posedge clk) begin
        if (log_wr) begin
            log_mem[log_count[LOG_AW-1:0]] <= fifo_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= log_mem[rd_addr];
        end
    end

endmodule
